obs_display: RTL and testbench

OBS_DISPLAY -- requirements
Module: obs_display

---
 rtl/obs_display.sv | 163 ++++++++++++++++
 tb/tb_obs_display.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/obs_display.sv
// Observation display: debounced view-select key chooses one of four CPU
// observation words, which is shown as 8 hex digits on a multiplexed 7-seg.
module obs_display #(
  parameter logic [19:0] DEB_CYCLES = 20'd1000000,
  parameter logic [16:0] SCAN_DIV   = 17'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_out,
  input  logic [31:0] IR_out,
  input  logic [31:0] MDR_out,
  input  logic [31:0] W_Data_out,
  input  logic        sel_key,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic [3:0]  view_led
);

  localparam logic [19:0] DEB_LAST  = DEB_CYCLES - 20'd1;
  localparam logic [16:0] SCAN_LAST = SCAN_DIV - 17'd1;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} deb_state_t;

  deb_state_t  state, state_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic        sync1, s;
  logic        adv, adv_d;
  logic [1:0]  view;
  logic [16:0] presc;
  logic [2:0]  idx;
  logic        tick;
  logic [31:0] frame, src;
  logic [3:0]  nib;
  logic [7:0]  hex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= sel_key;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) state_nxt = IDLE;
        else if (cnt == DEB_LAST) begin
          state_nxt = PRESSED;
          adv       = 1'b1;
        end else cnt_nxt = cnt + 20'd1;
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) state_nxt = PRESSED;
        else if (cnt == DEB_LAST) state_nxt = IDLE;
        else cnt_nxt = cnt + 20'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tick = (presc == SCAN_LAST);

  // A view change restarts the scan so the new word is shown from digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      view  <= '0;
      presc <= '0;
      idx   <= '0;
      adv_d <= 1'b0;
    end else begin
      adv_d <= adv;
      if (adv) begin
        view  <= view + 2'd1;
        presc <= '0;
        idx   <= '0;
      end else if (tick) begin
        presc <= '0;
        idx   <= idx + 3'd1;
      end else begin
        presc <= presc + 17'd1;
      end
    end
  end

  always_comb begin
    case (view)
      2'd0:    src = PC_out;
      2'd1:    src = IR_out;
      2'd2:    src = MDR_out;
      default: src = W_Data_out;
    endcase
  end

  // Frame only reloads at scan wrap or just after a view change, keeping digits coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame <= '0;
    else if (adv_d || (tick && idx == 3'd7)) frame <= src;
  end

  assign nib = frame[{idx, 2'b00} +: 4];

  always_comb begin
    case (nib)
      4'h0: hex = 8'hC0;
      4'h1: hex = 8'hF9;
      4'h2: hex = 8'hA4;
      4'h3: hex = 8'hB0;
      4'h4: hex = 8'h99;
      4'h5: hex = 8'h92;
      4'h6: hex = 8'h82;
      4'h7: hex = 8'hF8;
      4'h8: hex = 8'h80;
      4'h9: hex = 8'h90;
      4'hA: hex = 8'h88;
      4'hB: hex = 8'h83;
      4'hC: hex = 8'hC6;
      4'hD: hex = 8'hA1;
      4'hE: hex = 8'h86;
      default: hex = 8'h8E;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg      <= '1;
      an       <= '1;
      view_led <= 4'b0001;
    end else begin
      seg      <= hex;
      an       <= ~(8'b0000_0001 << idx);
      view_led <= 4'b0001 << view;
    end
  end

endmodule

// File: tb/tb_obs_display.sv
// Bench for obs_display: directed scenarios plus random key/source activity,
// every cycle checked against a cycle-level behavioural model.
module tb_obs_display;

  localparam logic [19:0] DEB = 20'd4;
  localparam logic [16:0] SD  = 17'd2;
  localparam int DEBI = 4;
  localparam int SDI  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc, ir, mdr, wd;
  logic        key = 1'b0;
  logic [7:0]  seg, an;
  logic [3:0]  view_led;

  obs_display #(.DEB_CYCLES(DEB), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n),
    .PC_out(pc), .IR_out(ir), .MDR_out(mdr), .W_Data_out(wd),
    .sel_key(key),
    .seg(seg), .an(an), .view_led(view_led)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model: key history, accepted-press flag with run length of stable samples,
  // view, cycles since scan restart, displayed frame and expected outputs.
  bit          m_k1, m_k2, m_pressed, m_adv_d;
  int          m_run, m_view, m_t;
  logic [31:0] m_frame;
  logic [7:0]  e_seg, e_an;
  logic [3:0]  e_led;

  function automatic logic [31:0] src_of(input int v);
    case (v)
      0: return pc;
      1: return ir;
      2: return mdr;
      default: return wd;
    endcase
  endfunction

  task automatic model_reset();
    m_k1 = 0; m_k2 = 0; m_pressed = 0; m_adv_d = 0;
    m_run = 0; m_view = 0; m_t = 0; m_frame = '0;
    e_seg = 8'hFF; e_an = 8'hFF; e_led = 4'b0001;
  endtask

  task automatic model_edge();
    int  idx;
    bit  tick, adv;
    int  nib;
    idx  = (m_t / SDI) % 8;
    tick = (m_t % SDI) == SDI - 1;
    adv  = 0;
    // A level change is accepted once it has been sampled DEB+1 edges in a row.
    if (!m_pressed) begin
      m_run = m_k2 ? m_run + 1 : 0;
      if (m_run == DEBI + 1) begin adv = 1; m_pressed = 1; m_run = 0; end
    end else begin
      m_run = !m_k2 ? m_run + 1 : 0;
      if (m_run == DEBI + 1) begin m_pressed = 0; m_run = 0; end
    end
    nib   = int'((m_frame >> (4 * idx)) & 32'hF);
    e_seg = hex_tbl[nib];
    e_an  = ~(8'h01 << idx);
    e_led = 4'b0001 << m_view;
    if (m_adv_d || (tick && idx == 7)) m_frame = src_of(m_view);
    if (adv) begin m_view = (m_view + 1) % 4; m_t = 0; end
    else m_t = (m_t + 1) % (8 * SDI);
    m_adv_d = adv;
    m_k2 = m_k1;
    m_k1 = key;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("seg", seg, e_seg);
    chk("an", an, e_an);
    chk("view_led", {4'b0, view_led}, {4'b0, e_led});
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    chk_all();
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit k);
    key = k;
    repeat (n) cyc();
  endtask

  task automatic async_rst();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all();
  endtask

  initial begin
    pc  = 32'h0000_0004;
    ir  = $urandom;
    mdr = $urandom;
    wd  = $urandom;
    #2;
    async_rst();
    @(negedge clk);
    repeat (3) cyc();
    chk("rst_seg", seg, 8'hFF);
    chk("rst_an", an, 8'hFF);
    chk("rst_led", {4'b0, view_led}, 8'h01);
    rst_n = 1'b1;

    // First edge shows digit 0 of the zero frame, then PC appears after the wrap.
    cyc();
    chk("first_seg", seg, 8'hC0);
    chk("first_an", an, 8'hFE);
    run(16, 0);
    chk("wrap_seg", seg, 8'h99);
    chk("wrap_an", an, 8'hFE);

    // Long hold gives one advance; release fully.
    run(20, 1);
    chk("hold_led", {4'b0, view_led}, 8'h02);
    run(24, 0);

    // Short bounces are ignored.
    run(2, 1); run(1, 0); run(2, 1); run(12, 0);
    chk("bounce_led", {4'b0, view_led}, 8'h02);

    // Four clean presses from view 0, including a mid-frame W_Data change at view 3.
    async_rst();
    repeat (2) cyc();
    rst_n = 1'b1;
    run(3, 0);
    run(8, 1); run(9, 0);
    chk("press1_led", {4'b0, view_led}, 8'h02);
    run(8, 1); run(9, 0);
    chk("press2_led", {4'b0, view_led}, 8'h04);
    run(8, 1); run(9, 0);
    chk("press3_led", {4'b0, view_led}, 8'h08);
    run(20, 0);
    wd = $urandom;
    run(30, 0);
    run(8, 1); run(9, 0);
    chk("press4_led", {4'b0, view_led}, 8'h01);

    // Reset mid-debounce with key still held: press aborted, then redone once.
    run(4, 1);
    async_rst();
    repeat (3) cyc();
    rst_n = 1'b1;
    run(8, 1);
    chk("rehold_led", {4'b0, view_led}, 8'h02);
    run(20, 1);
    chk("rehold_once", {4'b0, view_led}, 8'h02);
    run(10, 0);

    // Random key activity, source changes and occasional resets.
    for (int i = 0; i < 80; i++) begin
      int len;
      len = int'($urandom_range(1, 9));
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: pc  = $urandom;
          1: ir  = $urandom;
          2: mdr = $urandom;
          default: wd = $urandom;
        endcase
      end
      if ($urandom_range(0, 24) == 0) begin
        async_rst();
        cyc();
        rst_n = 1'b1;
      end
      run(len, bit'($urandom_range(0, 1)));
    end
    run(20, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
